snake_logic: RTL and testbench



---
 rtl/snake_logic_pkg.sv | 72 +++++++
 rtl/snake_body_fifo.sv | 52 +++++
 rtl/snake_logic.sv | 188 ++++++++++++++++++
 tb/tb_snake_logic.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_logic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_logic_pkg
// Brief    : Board geometry, direction codes, status bit indices and helpers
//            shared by the snake board datapath.
// Revision : 1.0 - initial release
// ============================================================================
package snake_logic_pkg;

    localparam int c_POS_W = 6;
    localparam int c_BOARD = 8;
    localparam int c_CELLS = c_BOARD * c_BOARD;
    localparam int c_LEN_W = 7;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    localparam int c_TICK_BIT      = 0;
    localparam int c_NO_UPDATE_BIT = 1;
    localparam int c_DONE_BIT      = 0;
    localparam int c_GAME_END_BIT  = 1;

    typedef logic [c_POS_W-1:0] pos_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CALC       = 3'd1,
        S_CHECK      = 3'd2,
        S_COMMIT     = 3'd3,
        S_FOOD_REQ   = 3'd4,
        S_FOOD_PROBE = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    // Row/column arithmetic is 3 bits wide, so the board wraps at every edge.
    function automatic pos_t step_pos(input pos_t p, input logic [1:0] dir);
        logic [2:0] row;
        logic [2:0] col;
        row = p[5:3];
        col = p[2:0];
        case (dir)
            c_DIR_UP:    row = row + 3'd1;
            c_DIR_DOWN:  row = row - 3'd1;
            c_DIR_LEFT:  col = col - 3'd1;
            c_DIR_RIGHT: col = col + 3'd1;
        endcase
        return {row, col};
    endfunction

    function automatic logic [c_CELLS-1:0] cell_mask(input pos_t p);
        return {{(c_CELLS-1){1'b0}}, 1'b1} << p;
    endfunction

    function automatic logic [c_CELLS-1:0] led_image(input logic [c_CELLS-1:0] occ,
                                                     input pos_t head, input logic vis,
                                                     input pos_t food);
        return (occ & ~cell_mask(head)) | (vis ? cell_mask(head) : '0) | cell_mask(food);
    endfunction

    function automatic logic [c_CELLS-1:0] init_occ(input int len);
        logic [c_CELLS-1:0] m;
        m = '0;
        for (int i = 0; i < c_BOARD; i++) begin
            if (i < len) m[3*c_BOARD + i] = 1'b1;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_body_fifo.sv
`default_nettype none
// ============================================================================
// Module   : snake_body_fifo
// Brief    : 64-entry circular buffer of body cells, tail at the read side and
//            head at the write side; reset loads the initial body on row 3.
// Revision : 1.0 - initial release
// ============================================================================
module snake_body_fifo
    import snake_logic_pkg::*;
#(
    parameter int INIT_LEN = 2
) (
    input  logic               clka,
    input  logic               restart,
    input  logic               push,
    input  logic               pop,
    input  pos_t               push_pos,
    output pos_t               head_pos,
    output pos_t               tail_pos,
    output logic [c_LEN_W-1:0] len
);

    pos_t               r_mem [c_CELLS];
    logic [5:0]         r_head_ptr;
    logic [5:0]         r_tail_ptr;
    logic [c_LEN_W-1:0] r_len;

    always_ff @(negedge clka or posedge restart) begin
        if (restart) begin
            for (int i = 0; i < c_CELLS; i++) begin
                r_mem[i] <= (i < INIT_LEN) ? {3'd3, 3'(i)} : '0;
            end
            r_head_ptr <= 6'(INIT_LEN - 1);
            r_tail_ptr <= '0;
            r_len      <= c_LEN_W'(INIT_LEN);
        end else begin
            if (push) begin
                r_mem[r_head_ptr + 6'd1] <= push_pos;
                r_head_ptr               <= r_head_ptr + 6'd1;
            end
            if (pop) r_tail_ptr <= r_tail_ptr + 6'd1;
            if (push && !pop)      r_len <= r_len + 7'd1;
            else if (pop && !push) r_len <= r_len - 7'd1;
        end
    end

    assign head_pos = r_mem[r_head_ptr];
    assign tail_pos = r_mem[r_tail_ptr];
    assign len      = r_len;

endmodule
`default_nettype wire

// File: rtl/snake_logic.sv
`default_nettype none
// ============================================================================
// Module   : snake_logic
// Brief    : Snake board datapath: per-tick move/collide/grow/food placement
//            or head blink, producing the 8x8 LED image and status bits.
// Revision : 1.0 - initial release
// ============================================================================
module snake_logic
    import snake_logic_pkg::*;
#(
    parameter int         INIT_LEN  = 2,
    parameter logic [5:0] INIT_FOOD = 6'o36
) (
    input  logic               clka,
    input  logic               restart,
    input  logic [1:0]         to_logic,
    input  logic [1:0]         direction_state,
    output logic [1:0]         from_logic,
    output logic [c_BOARD-1:0] led_array [c_BOARD],
    output logic               prng_req,
    input  logic               prng_ack,
    input  logic [5:0]         prng_data
);

    localparam pos_t               c_INIT_HEAD = pos_t'(3*c_BOARD + INIT_LEN - 1);
    localparam logic [c_CELLS-1:0] c_INIT_OCC  = init_occ(INIT_LEN);
    localparam logic [c_CELLS-1:0] c_INIT_LED  = led_image(c_INIT_OCC, c_INIT_HEAD, 1'b1, INIT_FOOD);

    state_t             r_state, w_state_nxt;
    logic               r_tick_prev;
    pos_t               r_new_head, w_new_head_nxt;
    logic               r_grow, w_grow_nxt;
    pos_t               r_cand, w_cand_nxt;
    pos_t               r_food, w_food_nxt;
    logic [c_CELLS-1:0] r_occ, w_occ_nxt;
    logic               r_head_vis, w_vis_nxt;
    logic               r_done, w_done_nxt;
    logic               r_game_end, w_game_end_nxt;
    logic               r_prng_req, w_req_nxt;
    logic [c_CELLS-1:0] r_led, w_led_nxt;

    logic               w_edge, w_eat, w_hit, w_push, w_pop;
    pos_t               w_head_pos, w_tail_pos, w_head_nxt;
    logic [c_LEN_W-1:0] w_len;

    snake_body_fifo #(.INIT_LEN(INIT_LEN)) u_body (
        .clka     (clka),
        .restart  (restart),
        .push     (w_push),
        .pop      (w_pop),
        .push_pos (r_new_head),
        .head_pos (w_head_pos),
        .tail_pos (w_tail_pos),
        .len      (w_len)
    );

    assign w_edge = to_logic[c_TICK_BIT] && !r_tick_prev;
    assign w_eat  = (r_new_head == r_food);
    // The tail cell is being vacated on a non-growing move, so it is not an obstacle.
    assign w_hit  = r_occ[r_new_head] && !((r_new_head == w_tail_pos) && !w_eat);

    always_comb begin
        w_state_nxt    = r_state;
        w_new_head_nxt = r_new_head;
        w_grow_nxt     = r_grow;
        w_cand_nxt     = r_cand;
        w_food_nxt     = r_food;
        w_occ_nxt      = r_occ;
        w_vis_nxt      = r_head_vis;
        w_done_nxt     = r_done;
        w_game_end_nxt = r_game_end;
        w_req_nxt      = r_prng_req;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_done_nxt = 1'b0;
                    if (to_logic[c_NO_UPDATE_BIT]) begin
                        w_vis_nxt   = !r_head_vis;
                        w_state_nxt = S_DONE;
                    end else if (r_game_end) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_new_head_nxt = step_pos(w_head_pos, direction_state);
                w_state_nxt    = S_CHECK;
            end
            S_CHECK: begin
                w_grow_nxt = w_eat;
                if (w_hit) begin
                    w_game_end_nxt = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = S_DONE;
                end else begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_push    = 1'b1;
                w_pop     = !r_grow;
                w_vis_nxt = 1'b1;
                if (!r_grow) w_occ_nxt[w_tail_pos] = 1'b0;
                w_occ_nxt[r_new_head] = 1'b1;
                if (r_grow && (w_len == 7'd63)) begin
                    w_game_end_nxt = 1'b1;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = S_DONE;
                end else if (r_grow) begin
                    w_req_nxt   = 1'b1;
                    w_state_nxt = S_FOOD_REQ;
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_FOOD_REQ: begin
                if (prng_ack) begin
                    w_cand_nxt  = prng_data;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_FOOD_PROBE;
                end
            end
            S_FOOD_PROBE: begin
                if (!r_occ[r_cand]) begin
                    w_food_nxt  = r_cand;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cand_nxt = r_cand + 6'd1;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The image is built from next-state values so it lands with the state change.
    assign w_head_nxt = (r_state == S_COMMIT) ? r_new_head : w_head_pos;
    assign w_led_nxt  = led_image(w_occ_nxt, w_head_nxt, w_vis_nxt, w_food_nxt);

    always_ff @(negedge clka or posedge restart) begin
        if (restart) begin
            r_state     <= S_IDLE;
            r_tick_prev <= 1'b0;
            r_new_head  <= '0;
            r_grow      <= 1'b0;
            r_cand      <= '0;
            r_food      <= INIT_FOOD;
            r_occ       <= c_INIT_OCC;
            r_head_vis  <= 1'b1;
            r_done      <= 1'b1;
            r_game_end  <= 1'b0;
            r_prng_req  <= 1'b0;
            r_led       <= c_INIT_LED;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_prev <= to_logic[c_TICK_BIT];
            r_new_head  <= w_new_head_nxt;
            r_grow      <= w_grow_nxt;
            r_cand      <= w_cand_nxt;
            r_food      <= w_food_nxt;
            r_occ       <= w_occ_nxt;
            r_head_vis  <= w_vis_nxt;
            r_done      <= w_done_nxt;
            r_game_end  <= w_game_end_nxt;
            r_prng_req  <= w_req_nxt;
            r_led       <= w_led_nxt;
        end
    end

    assign from_logic[c_DONE_BIT]     = r_done;
    assign from_logic[c_GAME_END_BIT] = r_game_end;
    assign prng_req                   = r_prng_req;

    for (genvar r = 0; r < c_BOARD; r++) begin : g_row
        assign led_array[r] = r_led[r*c_BOARD +: c_BOARD];
    end

endmodule
`default_nettype wire

// File: tb/tb_snake_logic.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_logic
// Brief    : Scoreboard bench for snake_logic against a queue-based game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_logic;

    logic       clka = 1'b0;
    logic       restart = 1'b1;
    logic [1:0] to_logic = 2'b00;
    logic [1:0] direction_state = 2'd0;
    logic [1:0] from_logic;
    logic [7:0] led_array [8];
    logic       prng_req;
    logic       prng_ack = 1'b0;
    logic [5:0] prng_data = 6'd0;

    snake_logic #(.INIT_LEN(2), .INIT_FOOD(6'o36)) dut (
        .clka            (clka),
        .restart         (restart),
        .to_logic        (to_logic),
        .direction_state (direction_state),
        .from_logic      (from_logic),
        .led_array       (led_array),
        .prng_req        (prng_req),
        .prng_ack        (prng_ack),
        .prng_data       (prng_data)
    );

    always #5 clka = ~clka;

    int cyc = 0;
    always @(negedge clka) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] led;
        logic        gend;
        int          lat;
        int          t0;
    } exp_t;
    exp_t exp_q[$];

    // Game model: body queue with tail at index 0 and head at the back.
    int body[$];
    int food;
    bit vis;
    bit gend;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [63:0] dut_led();
        logic [63:0] v;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                v[r*8+c] = led_array[r][c];
        return v;
    endfunction

    function automatic logic [63:0] model_led();
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < body.size() - 1; i++) m[body[i]] = 1'b1;
        if (vis) m[body[body.size()-1]] = 1'b1;
        m[food] = 1'b1;
        return m;
    endfunction

    function automatic bit in_body(input int p, input bit skip_tail);
        for (int i = 0; i < body.size(); i++)
            if (!(skip_tail && i == 0) && body[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int step(input int p, input int dir);
        int row, col;
        row = p / 8;
        col = p % 8;
        case (dir)
            0: row = (row + 1) % 8;
            1: row = (row + 7) % 8;
            2: col = (col + 7) % 8;
            default: col = (col + 1) % 8;
        endcase
        return row * 8 + col;
    endfunction

    task automatic model_reset();
        body.delete();
        body.push_back(3*8 + 0);
        body.push_back(3*8 + 1);
        food = 3*8 + 6;
        vis  = 1'b1;
        gend = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_status"}, from_logic, 2'b01);
        check({tag, "_prng_req"}, prng_req, 0);
        check({tag, "_led"}, dut_led(), model_led());
    endtask

    task automatic apply_restart();
        @(posedge clka);
        to_logic = 2'b00;
        prng_ack = 1'b0;
        restart  = 1'b1;
        @(posedge clka);
        #2 restart = 1'b0;
        model_reset();
        exp_q.delete();
        @(posedge clka);
        reset_checks("reset");
    endtask

    // Monitor: every rising LOGIC_DONE retires one scoreboard entry.
    exp_t m_e;
    initial begin
        bit prev;
        prev = 1'b1;
        forever begin
            @(posedge clka);
            if (restart) begin
                prev = 1'b1;
            end else begin
                if (from_logic[0] && !prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", exp_q.size(), 1);
                    end else begin
                        m_e = exp_q.pop_front();
                        check("latency", 64'(cyc - m_e.t0), 64'(m_e.lat));
                        check("game_end", from_logic[1], m_e.gend);
                        check("led_image", dut_led(), m_e.led);
                    end
                end
                prev = from_logic[0];
            end
        end
    end

    task automatic do_tick(input int nu, input int dir, input int w, input int pv);
        exp_t e;
        int   nh, probes, k;
        bit   eat, need_prng;
        need_prng = 1'b0;
        if (nu != 0) begin
            vis   = !vis;
            e.lat = 2;
        end else if (gend) begin
            e.lat = 2;
        end else begin
            nh  = step(body[body.size()-1], dir);
            eat = (nh == food);
            if (in_body(nh, !eat)) begin
                gend  = 1'b1;
                e.lat = 3;
            end else begin
                if (!eat) void'(body.pop_front());
                body.push_back(nh);
                vis = 1'b1;
                if (!eat) begin
                    e.lat = 4;
                end else if (body.size() == 64) begin
                    gend  = 1'b1;
                    e.lat = 4;
                end else begin
                    need_prng = 1'b1;
                    probes    = 1;
                    food      = pv;
                    while (in_body(food, 1'b0)) begin
                        food = (food + 1) % 64;
                        probes++;
                    end
                    e.lat = 5 + w + probes;
                end
            end
        end
        e.led  = model_led();
        e.gend = gend;

        @(posedge clka);
        e.t0 = cyc;
        exp_q.push_back(e);
        direction_state = 2'(dir);
        to_logic        = {nu != 0, 1'b1};
        if (need_prng) begin
            k = 0;
            do begin
                @(posedge clka);
                k++;
            end while (!prng_req && k < 50);
            check("prng_req_rise_cycle", 64'(k), 64'd4);
            repeat (w) @(posedge clka);
            prng_data = 6'(pv);
            prng_ack  = 1'b1;
            @(posedge clka);
            prng_ack  = 1'b0;
            prng_data = 6'($urandom);
            check("prng_req_drop", prng_req, 0);
        end else begin
            @(posedge clka);
        end
        k = 0;
        while (!from_logic[0] && k < 300) begin
            @(posedge clka);
            k++;
        end
        check("done_seen", from_logic[0], 1);
        to_logic = 2'b00;
        repeat ($urandom_range(0, 2)) @(posedge clka);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        model_reset();
        repeat (3) @(posedge clka);
        restart = 1'b0;
        @(posedge clka);
        reset_checks("power_on");

        // Straight run, two eats with occupied PRNG candidates, edge wrap, then self-collision.
        do_tick(0, 3, 0, 0);
        do_tick(0, 3, 0, 0);
        do_tick(0, 3, 0, 0);
        do_tick(0, 3, 0, 0);
        do_tick(0, 3, 1, 6'o35);
        do_tick(0, 3, 0, 6'o34);
        do_tick(0, 3, 0, 0);
        do_tick(0, 0, 2, 6'o00);
        do_tick(0, 3, 0, 0);
        do_tick(0, 1, 0, 0);
        do_tick(0, 2, 0, 0);
        do_tick(1, 0, 0, 0);
        do_tick(1, 0, 0, 0);
        do_tick(0, 3, 0, 0);

        // Length-4 square loop chasing its own tail.
        apply_restart();
        repeat (4) do_tick(0, 3, 0, 0);
        do_tick(0, 3, 0, 6'o37);
        do_tick(0, 3, 3, 6'o77);
        do_tick(0, 0, 0, 0);
        do_tick(0, 2, 0, 0);
        do_tick(0, 1, 0, 0);
        do_tick(0, 3, 0, 0);
        do_tick(0, 0, 0, 0);

        // Restart while a food request is outstanding; the late ack must be ignored.
        apply_restart();
        repeat (4) do_tick(0, 3, 0, 0);
        @(posedge clka);
        direction_state = 2'd3;
        to_logic        = 2'b01;
        k = 0;
        while (!prng_req && k < 50) begin
            @(posedge clka);
            k++;
        end
        check("abort_req_seen", prng_req, 1);
        @(posedge clka);
        #2 restart = 1'b1;
        to_logic = 2'b00;
        model_reset();
        exp_q.delete();
        #1 reset_checks("abort_restart");
        @(posedge clka);
        #2 restart = 1'b0;
        @(posedge clka);
        prng_data = 6'o12;
        prng_ack  = 1'b1;
        @(posedge clka);
        prng_ack  = 1'b0;
        repeat (5) @(posedge clka);
        reset_checks("late_ack");
        do_tick(0, 3, 0, 0);

        // Randomised play, restarting some time after each game over.
        apply_restart();
        for (int i = 0; i < 200; i++) begin
            if (gend && $urandom_range(0, 2) == 0)
                apply_restart();
            else
                do_tick(($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 63));
        end

        repeat (5) @(posedge clka);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
